// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Digit codes above BCD_MAX blank their slot.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam int MAX_DIGITS = 8;

    // Slice the low NUM_DIGITS bits for the all-anodes-off pattern.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/display_scan_controller_scan_slot_timer.sv
// Slot counter for one digit period: flags the end of blanking and of the slot.
// Wraps at REFRESH_DIV-1; clr holds it at zero.
module scan_slot_timer
    import display_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic blank_end,
    output logic slot_end
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] count;

    assign blank_end = (count == CW'(BLANK_CYCLES - 1));
    assign slot_end  = (count == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (slot_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed BCD digit scanner for a common-anode display.
// Double-buffered data, per-slot blanking and leading-zero suppression.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_data,
    output logic [3:0]              seg_bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp_out,
    output logic                    frame_done,
    output logic                    update_pending
);

    localparam int PW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_OFF[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
    localparam logic [PW-1:0]         PTR_LAST = PW'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    scan_state_t state;
    scan_state_t nxt_state;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt_ptr;

    digits_t in_digits;
    digits_t active;
    digits_t shadow;
    digits_t nxt_active;
    digits_t nxt_shadow;

    logic [NUM_DIGITS-1:0] active_dp;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] nxt_active_dp;
    logic [NUM_DIGITS-1:0] nxt_shadow_dp;
    logic [NUM_DIGITS-1:0] blank_mask;

    logic nxt_pending;
    logic blank_end;
    logic slot_end;
    logic timer_clr;
    logic boundary;
    logic bypass;
    logic hi_zero;
    logic drive_next;

    assign in_digits = digit_data;

    assign timer_clr = !enable || (state == IDLE);

    assign boundary = enable && (state == DRIVE)
                   && slot_end && (ptr == PTR_LAST);

    // Safe moments to touch active: display dark or frame just ended.
    assign bypass = (state == IDLE) || boundary;

    scan_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    always_comb begin
        nxt_state = state;
        nxt_ptr   = ptr;
        unique case (state)
            IDLE: begin
                nxt_ptr = '0;
                if (enable) begin
                    nxt_state = BLANK;
                end
            end
            BLANK: begin
                if (blank_end) begin
                    nxt_state = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_end) begin
                    nxt_state = BLANK;
                    nxt_ptr   = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_ptr   = '0;
            end
        endcase
        if (!enable) begin
            nxt_state = IDLE;
            nxt_ptr   = '0;
        end
    end

    always_comb begin
        nxt_active    = active;
        nxt_active_dp = active_dp;
        nxt_shadow    = shadow;
        nxt_shadow_dp = shadow_dp;
        nxt_pending   = update_pending;
        unique case (1'b1)
            load && bypass: begin
                nxt_active    = in_digits;
                nxt_active_dp = dp_data;
                nxt_shadow    = in_digits;
                nxt_shadow_dp = dp_data;
                nxt_pending   = 1'b0;
            end
            load && !bypass: begin
                nxt_shadow    = in_digits;
                nxt_shadow_dp = dp_data;
                nxt_pending   = 1'b1;
            end
            !load && bypass && update_pending: begin
                nxt_active    = shadow;
                nxt_active_dp = shadow_dp;
                nxt_pending   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Walk down from the top digit; hi_zero stays set while all so far are 0.
    always_comb begin
        hi_zero    = 1'b1;
        blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (nxt_active[i] == 4'd0);
            blank_mask[i] = (nxt_active[i] > BCD_MAX)
                         || ((LZ_BLANK != 0) && (i != 0) && hi_zero);
        end
    end

    assign drive_next = (nxt_state == DRIVE) && !blank_mask[nxt_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            active         <= '0;
            active_dp      <= '0;
            shadow         <= '0;
            shadow_dp      <= '0;
            update_pending <= 1'b0;
            seg_bcd        <= '0;
            an             <= AN_IDLE;
            dp_out         <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state          <= nxt_state;
            ptr            <= nxt_ptr;
            active         <= nxt_active;
            active_dp      <= nxt_active_dp;
            shadow         <= nxt_shadow;
            shadow_dp      <= nxt_shadow_dp;
            update_pending <= nxt_pending;
            seg_bcd        <= nxt_active[nxt_ptr];
            an             <= drive_next ? ~(AN_ONE << nxt_ptr) : AN_IDLE;
            dp_out         <= drive_next && nxt_active_dp[nxt_ptr];
            frame_done     <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller, LZ_BLANK=0 and =1 side by side.
// Stimulus queues per-cycle expectations; a negedge monitor pops and compares.
module tb_display_scan_controller;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    typedef struct {
        logic [3:0] an0;
        logic [3:0] an1;
        logic [3:0] seg;
        logic       care0;
        logic       care1;
        logic       dp0;
        logic       dp1;
        logic       fd;
        logic       pend;
    } exp_t;

    logic clk;
    logic rst_n;
    logic enable;
    logic load;
    logic [4*ND-1:0] digit_data;
    logic [ND-1:0] dp_data;

    logic [3:0] seg0, seg1;
    logic [ND-1:0] an0, an1;
    logic dp0, dp1, fd0, fd1, pend0, pend1;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    display_scan_controller #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC), .LZ_BLANK(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digit_data(digit_data), .dp_data(dp_data),
        .seg_bcd(seg0), .an(an0), .dp_out(dp0),
        .frame_done(fd0), .update_pending(pend0)
    );

    display_scan_controller #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC), .LZ_BLANK(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digit_data(digit_data), .dp_data(dp_data),
        .seg_bcd(seg1), .an(an1), .dp_out(dp1),
        .frame_done(fd1), .update_pending(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_idle(input int n, input logic care,
                             input logic [3:0] segv);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.an0 = 4'hF;
            e.an1 = 4'hF;
            e.seg = segv;
            e.care0 = care;
            e.care1 = care;
            e.dp0 = 1'b0;
            e.dp1 = 1'b0;
            e.fd = 1'b0;
            e.pend = 1'b0;
            sb.push_back(e);
        end
    endtask

    // Expected outputs for one frame (or its first ncyc cycles).
    task automatic push_frame(input logic [15:0] data, input logic [3:0] dpv,
                              input logic [3:0] bm0, input logic [3:0] bm1,
                              input logic fd_first, input int pend_from,
                              input int ncyc);
        exp_t e;
        int d;
        int c;
        logic drv0;
        logic drv1;
        logic [3:0] sel;
        for (int i = 0; i < ncyc; i++) begin
            d = i / RD;
            c = i % RD;
            sel = 4'b0001 << d;
            drv0 = (c >= BC) && !bm0[d];
            drv1 = (c >= BC) && !bm1[d];
            e.an0 = drv0 ? ~sel : 4'hF;
            e.an1 = drv1 ? ~sel : 4'hF;
            e.seg = data[4*d +: 4];
            e.care0 = !bm0[d];
            e.care1 = !bm1[d];
            e.dp0 = drv0 && dpv[d];
            e.dp1 = drv1 && dpv[d];
            e.fd = fd_first && (i == 0);
            e.pend = (i >= pend_from);
            sb.push_back(e);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        load = 1'b1;
        digit_data = d;
        dp_data = p;
        wait_neg(1);
        load = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("an_lz0", an0, e.an0);
                chk("an_lz1", an1, e.an1);
                chk("dp_lz0", {3'b0, dp0}, {3'b0, e.dp0});
                chk("dp_lz1", {3'b0, dp1}, {3'b0, e.dp1});
                chk("frame_done_lz0", {3'b0, fd0}, {3'b0, e.fd});
                chk("frame_done_lz1", {3'b0, fd1}, {3'b0, e.fd});
                chk("pending_lz0", {3'b0, pend0}, {3'b0, e.pend});
                chk("pending_lz1", {3'b0, pend1}, {3'b0, e.pend});
                if (e.care0) chk("seg_lz0", seg0, e.seg);
                if (e.care1) chk("seg_lz1", seg1, e.seg);
                cyc++;
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0;
        enable = 1'b0;
        load = 1'b0;
        digit_data = '0;
        dp_data = '0;
        @(negedge clk);
        #1;
        push_idle(2, 1'b1, 4'h0);
        wait_neg(2);

        // Load while idle goes straight to active.
        rst_n = 1'b1;
        push_idle(1, 1'b0, 4'h0);
        load_word(16'h1234, 4'b0101);

        // Frame A; 0x5678 arrives mid-frame and waits in the shadow.
        enable = 1'b1;
        push_frame(16'h1234, 4'b0101, 4'b0000, 4'b0000, 1'b0, 12, 32);
        wait_neg(12);
        load_word(16'h5678, 4'b1000);
        wait_neg(19);

        // Frame B; two loads, last one wins.
        push_frame(16'h5678, 4'b1000, 4'b0000, 4'b0000, 1'b1, 5, 32);
        wait_neg(5);
        load_word(16'h1111, 4'b0000);
        wait_neg(14);
        load_word(16'h2222, 4'b0010);
        wait_neg(11);

        // Frame C; load on the boundary cycle bypasses the shadow.
        push_frame(16'h2222, 4'b0010, 4'b0000, 4'b0000, 1'b1, 99, 32);
        wait_neg(32);

        // Frame D: digit 2 = 0xC blanks its slot.
        push_frame(16'h1C34, 4'b1111, 4'b0100, 4'b0100, 1'b1, 99, 32);
        load_word(16'h1C34, 4'b1111);
        wait_neg(31);

        // Frame E: leading zeros; enable drops mid-DRIVE of slot 2.
        push_frame(16'h0070, 4'b0000, 4'b0000, 4'b1100, 1'b1, 99, 20);
        load_word(16'h0070, 4'b0000);
        wait_neg(19);
        enable = 1'b0;
        push_idle(3, 1'b0, 4'h0);
        wait_neg(3);

        // Restart from digit 0, then reset mid-frame with data pending.
        enable = 1'b1;
        push_frame(16'h0070, 4'b0000, 4'b0000, 4'b1100, 1'b0, 10, 20);
        wait_neg(10);
        load_word(16'h9999, 4'b1111);
        wait_neg(9);
        rst_n = 1'b0;
        enable = 1'b0;
        push_idle(2, 1'b1, 4'h0);
        wait_neg(2);
        rst_n = 1'b1;
        push_idle(1, 1'b0, 4'h0);
        wait_neg(1);

        // All-zero data after reset: pending data must not reappear.
        enable = 1'b1;
        push_frame(16'h0000, 4'b0000, 4'b0000, 4'b1110, 1'b0, 99, 32);
        wait_neg(32);
        push_frame(16'h0000, 4'b0000, 4'b0000, 4'b1110, 1'b1, 99, 32);
        wait_neg(32);
        push_frame(16'h0000, 4'b0000, 4'b0000, 4'b1110, 1'b1, 99, 4);
        wait_neg(4);
        enable = 1'b0;
        push_idle(2, 1'b0, 4'h0);
        wait_neg(2);

        wait_neg(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left expected 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto one shared 4-bit-in / 7-segment-out decoder and a common-anode digit array.
- Sequences a digit pointer at a fixed refresh rate and inserts blanking slots against ghosting.
- Double-buffers display data so host updates never tear mid-frame.
- Sits between host logic and the combinational segment decoder; its seg_bcd output drives the decoder's b3..b0 inputs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 1000, clocks per digit slot (must be > BLANK_CYCLES + 1).
- BLANK_CYCLES, 2, clocks at the start of each slot with all anodes off.
- LZ_BLANK, 1, 1 = suppress leading zeros (the digit at index 0 is never suppressed).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  1 = scanning; 0 = display dark.
- load  in  1  one-cycle strobe that captures digit_data and dp_data.
- digit_data  in  4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (least significant).
- dp_data  in  NUM_DIGITS  decimal-point bit per digit.
- seg_bcd  out  4  code presented to the segment decoder.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when driving.
- dp_out  out  1  decimal point for the currently driven digit.
- frame_done  out  1  one-cycle pulse at the end of each full scan.
- update_pending  out  1  shadow holds data not yet shown.

Behaviour:
- Reset (clk edge with rst_n=0), all registered:
  - an = all ones; seg_bcd = 0; dp_out = 0; frame_done = 0; update_pending = 0.
  - ptr = 0; slot counter = 0; active and shadow registers = 0; state = IDLE.
- Reset asserted mid-slot or mid-frame takes effect on that edge and discards pending data.
- FSM states:
  - IDLE: enable=0; an = all ones; counter held at 0; ptr held at 0.
  - BLANK: slot counts 0..BLANK_CYCLES-1; an = all ones; seg_bcd = active[ptr] already presented so the decoder settles.
  - DRIVE: slot counts BLANK_CYCLES..REFRESH_DIV-1; an[ptr] = 0, all other anodes 1; dp_out = active_dp[ptr].
- Transitions:
  - IDLE -> BLANK on enable=1, ptr = 0.
  - BLANK -> DRIVE when count = BLANK_CYCLES-1.
  - DRIVE -> BLANK when count = REFRESH_DIV-1; ptr advances, with ptr = NUM_DIGITS-1 wrapping to 0.
  - Any state -> IDLE on enable=0, taking effect on the next edge; an goes all ones that cycle and ptr resets to 0.
- Frame boundary (DRIVE, count = REFRESH_DIV-1, ptr = NUM_DIGITS-1):
  - frame_done = 1 for exactly the next cycle.
  - If update_pending, shadow is copied to active and update_pending clears.
- Load:
  - load=1 writes the shadow and sets update_pending.
  - A second load before the boundary overwrites the shadow (last write wins).
  - load on the boundary cycle bypasses straight to active and update_pending stays 0.
  - load while in IDLE copies immediately to active.
- Blanking rules (an stays all ones for the whole slot; the slot still consumes time):
  - A digit code of 10..15 blanks its slot.
  - With LZ_BLANK=1, a zero digit blanks its slot when every higher-indexed digit is also zero.
  - dp_out = 0 when the slot is blanked.
- Timing:
  - Outputs are registered; latency enable -> first anode low = BLANK_CYCLES+1 clocks.
  - Frame period = NUM_DIGITS*REFRESH_DIV clocks.
- Width rules:
  - Counter width = clog2(REFRESH_DIV).
  - ptr width = clog2(NUM_DIGITS), minimum 1.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BLANK, DRIVE};
  - constant BCD_MAX = 9;
  - constant AN_OFF = all ones (width function of NUM_DIGITS).
- One natural sub-module: scan_slot_timer (slot counter with blank_end and slot_end flags, sync clear).
- Leading-zero mask is combinational inside the top module.

Test Plan:
- Sim params NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=0.
  - Reset then enable=1 with active=0x1234 -> an sequence 1111(x2), 1110(x6, seg_bcd=4), 1111(x2), 1101(x6, seg_bcd=3), ...; frame_done pulses once every 32 clocks.
  - load 0x5678 at mid-frame -> update_pending=1; display keeps 0x1234 until frame_done; the next frame shows 8,7,6,5; pending clears.
  - load 0x1111 then 0x2222 within one frame -> the next frame shows 2222 only; load coinciding with the boundary cycle -> shown in the immediately next frame, pending=0.
  - Digit 2 = 0xC -> the slot for digit 2 has an=1111 for all 8 clocks and dp_out=0; the other digits are unaffected.
- LZ_BLANK=1, data 0x0070 -> digits 3 and 2 blanked, digit 1 shows 7, digit 0 shows 0; data 0x0000 -> only digit 0 lit.
- enable dropped mid-DRIVE -> an=1111 the next clock, ptr=0; rst_n=0 mid-frame -> all outputs at reset values the next clock and pending discarded.
